// File: rtl/stm32_bus_bridge_if.sv
// Byte-wide STM32 parallel bus side of stm32_bus_bridge.
// The top level splits the tristate DATA_BUS into in/out/OE before it reaches this interface.
interface stm32_bus_bridge_if;
    logic       DATA_SYNC;
    logic [7:0] DATA_BUS_IN;
    logic [7:0] DATA_BUS_OUT;
    logic       DATA_BUS_OE;

    modport master (output DATA_SYNC, DATA_BUS_IN, input  DATA_BUS_OUT, DATA_BUS_OE);
    modport slave  (input  DATA_SYNC, DATA_BUS_IN, output DATA_BUS_OUT, DATA_BUS_OE);
endinterface

// File: rtl/stm32_bus_bridge.sv
// Byte-wide command bridge between the STM32 bus and the DDC/DUC core.
// Optional BUS_CRC_EN: CRC-8 (poly 0x07) on register writes and on every streamed RX frame.
module stm32_bus_bridge #(
    parameter int         NUM_RX   = 2,
    parameter int         IQ_WIDTH = 32,
    parameter int         NUM_REGS = 24,
    parameter logic [7:0] VERSION  = 8'h02
) (
    input  logic                         clk_in,
    input  logic                         reset_n,
    stm32_bus_bridge_if.slave            bus,
    input  logic [NUM_RX*2*IQ_WIDTH-1:0] rx_iq_data,
    input  logic                         rx_iq_valid,
    input  logic [NUM_RX-1:0]            rx_chan_en,
    output logic                         IQ_RX_READ_REQ,
    output logic [IQ_WIDTH-1:0]          TX_I,
    output logic [IQ_WIDTH-1:0]          TX_Q,
    output logic                         tx_iq_valid,
    output logic [NUM_REGS*8-1:0]        cfg_regs,
    output logic                         cfg_wr_strobe,
    input  logic [31:0]                  status_in,
    output logic [7:0]                   stage_debug
);
    localparam int BYTES = IQ_WIDTH / 8;
    localparam int CH_W  = 2 * IQ_WIDTH;
    localparam int FR_W  = NUM_RX * CH_W;
    localparam int FRAME = NUM_RX * 2 * BYTES;
    localparam int M1    = (FRAME > NUM_REGS) ? FRAME : NUM_REGS;
    localparam int M2    = (M1 > 4) ? M1 : 4;
    localparam int CW    = $clog2(M2 + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_ECHO_RX, S_ECHO_TX, S_WREG, S_STAT, S_TXIQ, S_RXIQ, S_INFO
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt, r_len, w_len;
    logic [FR_W-1:0]       r_frame, w_frame;
    logic [NUM_REGS*8-1:0] r_shadow, w_shadow, r_cfg;
    logic [CH_W-1:0]       r_txsh, w_txsh;
    logic [IQ_WIDTH-1:0]   r_tx_i, r_tx_q;
    logic [31:0]           r_stat;
    logic [7:0]            r_out, w_din;
    logic                  r_oe, r_rd_req, r_tx_vld, r_cfg_stb, r_ovr, r_seen;
    logic                  w_sync, w_latch, w_rx_last, w_ovr_clr, w_bit6, w_unused;

`ifdef BUS_CRC_EN
    logic [7:0] r_crc;
    logic       r_crc_err;

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] x;
        x = c ^ d;
        for (int i = 0; i < 8; i++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        return x;
    endfunction

    assign w_bit6    = r_crc_err;
    assign w_rx_last = (r_len == '0) || (r_cnt == r_len);
`else
    assign w_bit6    = r_stat[30];
    assign w_rx_last = (r_len == '0) || (r_cnt == r_len - CW'(1));
`endif

    assign w_sync    = bus.DATA_SYNC;
    assign w_din     = bus.DATA_BUS_IN;
    assign w_latch   = w_sync ? (w_din == 8'd4) : (r_state == S_RXIQ && w_rx_last);
    assign w_ovr_clr = !w_sync && r_state == S_STAT && r_cnt == '0;
    assign w_txsh    = {r_txsh[CH_W-9:0], w_din};
    assign w_unused  = &{1'b0, r_stat[31], r_stat[30]};

    // Pack enabled channels to the top, lowest index first, each as {Q, I}.
    always_comb begin
        w_frame = '0;
        w_len   = '0;
        for (int n = NUM_RX - 1; n >= 0; n--) begin
            if (rx_chan_en[n]) begin
                w_frame = w_frame >> CH_W;
                w_frame[FR_W-1 -: CH_W] = {rx_iq_data[n*CH_W +: IQ_WIDTH],
                                           rx_iq_data[n*CH_W+IQ_WIDTH +: IQ_WIDTH]};
                w_len = w_len + CW'(2 * BYTES);
            end
        end
    end

    always_comb begin
        w_shadow = r_shadow;
        if (r_cnt < CW'(NUM_REGS)) w_shadow[r_cnt*8 +: 8] = w_din;
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;   r_cnt    <= '0;   r_shadow  <= '0;  r_cfg    <= '0;
            r_txsh  <= '0;       r_tx_i   <= '0;   r_tx_q    <= '0;  r_stat   <= '0;
            r_out   <= '0;       r_oe     <= 1'b0; r_tx_vld  <= 1'b0; r_cfg_stb <= 1'b0;
`ifdef BUS_CRC_EN
            r_crc   <= '0;       r_crc_err <= 1'b0;
`endif
        end else begin
            r_tx_vld  <= 1'b0;
            r_cfg_stb <= 1'b0;
            if (w_sync) begin
                r_cnt    <= '0;
                r_shadow <= '0;
                r_out    <= '0;
                r_stat   <= status_in;
`ifdef BUS_CRC_EN
                r_crc    <= '0;
`endif
                case (w_din)
                    8'd0:    begin r_state <= S_ECHO_RX; r_oe <= 1'b0; end
                    8'd1:    begin r_state <= S_WREG;    r_oe <= 1'b0; end
                    8'd2:    begin r_state <= S_STAT;    r_oe <= 1'b1; end
                    8'd3:    begin r_state <= S_TXIQ;    r_oe <= 1'b0; end
                    8'd4:    begin r_state <= S_RXIQ;    r_oe <= 1'b1; end
                    8'd8:    begin r_state <= S_INFO;    r_oe <= 1'b1; end
                    default: begin r_state <= S_IDLE;    r_oe <= 1'b0; end
                endcase
            end else begin
                case (r_state)
                    S_ECHO_RX: begin r_out <= w_din; r_oe <= 1'b1; r_state <= S_ECHO_TX; end
                    S_ECHO_TX: begin r_oe <= 1'b0; r_state <= S_ECHO_RX; end
                    S_WREG: begin
                        r_shadow <= w_shadow;
`ifdef BUS_CRC_EN
                        if (r_cnt < CW'(NUM_REGS)) begin
                            r_crc <= crc8(r_crc, w_din);
                            r_cnt <= r_cnt + CW'(1);
                        end else begin
                            if (w_din == r_crc) begin r_cfg <= r_shadow; r_cfg_stb <= 1'b1; end
                            else r_crc_err <= 1'b1;
                            r_state <= S_IDLE;
                        end
`else
                        if (r_cnt == CW'(NUM_REGS - 1)) begin
                            r_cfg <= w_shadow; r_cfg_stb <= 1'b1; r_state <= S_IDLE;
                        end else r_cnt <= r_cnt + CW'(1);
`endif
                    end
                    S_STAT: begin
                        r_cnt <= r_cnt + CW'(1);
                        case (int'(r_cnt))
                            0: begin
                                r_out <= {r_ovr, w_bit6, r_stat[29:24]};
`ifdef BUS_CRC_EN
                                r_crc_err <= 1'b0;
`endif
                            end
                            1:       r_out <= r_stat[23:16];
                            2:       r_out <= r_stat[15:8];
                            3:       r_out <= r_stat[7:0];
                            default: begin r_out <= '0; r_oe <= 1'b0; r_state <= S_IDLE; end
                        endcase
                    end
                    S_TXIQ: begin
                        r_txsh <= w_txsh;
                        if (r_cnt == CW'(2 * BYTES - 1)) begin
                            r_tx_q <= w_txsh[CH_W-1 -: IQ_WIDTH];
                            r_tx_i <= w_txsh[IQ_WIDTH-1:0];
                            r_tx_vld <= 1'b1;
                            r_state <= S_IDLE;
                        end else r_cnt <= r_cnt + CW'(1);
                    end
                    S_RXIQ: begin
                        r_oe <= 1'b1;
                        if (r_len == '0) r_out <= '0;
                        else if (r_cnt < r_len) begin
                            r_out <= r_frame[FR_W-1 -: 8];
`ifdef BUS_CRC_EN
                            r_crc <= crc8(r_crc, r_frame[FR_W-1 -: 8]);
                        end else begin
                            r_out <= r_crc;
                            r_crc <= '0;
`endif
                        end
                        r_cnt <= w_rx_last ? '0 : r_cnt + CW'(1);
                    end
                    S_INFO: begin
                        r_cnt <= r_cnt + CW'(1);
                        case (int'(r_cnt))
                            0:       r_out <= 8'(NUM_RX);
                            1:       r_out <= 8'(IQ_WIDTH);
                            2:       r_out <= 8'(NUM_REGS);
                            3:       r_out <= VERSION;
                            default: begin r_out <= '0; r_oe <= 1'b0; r_state <= S_IDLE; end
                        endcase
                    end
                    default: begin r_oe <= 1'b0; r_state <= S_IDLE; end
                endcase
            end
        end
    end

    // Frame latch and overrun tracking; a strobe on a latch edge opens the new interval.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_frame <= '0; r_len <= '0; r_rd_req <= 1'b0; r_seen <= 1'b0; r_ovr <= 1'b0;
        end else begin
            r_rd_req <= 1'b0;
            if (w_latch) begin
                r_frame  <= w_frame;
                r_len    <= w_len;
                r_rd_req <= 1'b1;
                r_seen   <= rx_iq_valid;
            end else if (r_state == S_RXIQ && !w_sync) begin
                r_frame <= r_frame << 8;
                if (rx_iq_valid) begin
                    r_seen <= 1'b1;
                    if (r_seen) r_ovr <= 1'b1;
                end
            end
            if (w_ovr_clr) r_ovr <= 1'b0;
        end
    end

    assign bus.DATA_BUS_OUT = r_out;
    assign bus.DATA_BUS_OE  = r_oe;
    assign IQ_RX_READ_REQ   = r_rd_req;
    assign TX_I             = r_tx_i;
    assign TX_Q             = r_tx_q;
    assign tx_iq_valid      = r_tx_vld;
    assign cfg_regs         = r_cfg;
    assign cfg_wr_strobe    = r_cfg_stb;
    assign stage_debug      = {5'd0, r_state};
endmodule

// File: tb/tb_stm32_bus_bridge.sv
// Directed bench for stm32_bus_bridge: vector table for single-byte commands,
// hand sequences for register write/abort, TX load, RX streaming and overrun.
module tb_stm32_bus_bridge;
    localparam int NUM_RX = 2, IQ_WIDTH = 32, NUM_REGS = 24;
`ifdef BUS_CRC_EN
    localparam logic [7:0] B0 = 8'h3C;  // bit 6 reports CRC error, clear here
    localparam int         FX = 1;
`else
    localparam logic [7:0] B0 = 8'h7C;  // bit 6 passes status_in[30]
    localparam int         FX = 0;
`endif

    logic clk_in = 1'b0, reset_n = 1'b0;
    always #5 clk_in = ~clk_in;

    stm32_bus_bridge_if bus();
    logic [NUM_RX*2*IQ_WIDTH-1:0] rx_iq_data;
    logic                         rx_iq_valid;
    logic [NUM_RX-1:0]            rx_chan_en;
    logic                         IQ_RX_READ_REQ, tx_iq_valid, cfg_wr_strobe;
    logic [IQ_WIDTH-1:0]          TX_I, TX_Q;
    logic [NUM_REGS*8-1:0]        cfg_regs;
    logic [31:0]                  status_in;
    logic [7:0]                   stage_debug;

    stm32_bus_bridge #(.NUM_RX(NUM_RX), .IQ_WIDTH(IQ_WIDTH), .NUM_REGS(NUM_REGS), .VERSION(8'h02)) dut (
        .clk_in(clk_in), .reset_n(reset_n), .bus(bus),
        .rx_iq_data(rx_iq_data), .rx_iq_valid(rx_iq_valid), .rx_chan_en(rx_chan_en),
        .IQ_RX_READ_REQ(IQ_RX_READ_REQ), .TX_I(TX_I), .TX_Q(TX_Q), .tx_iq_valid(tx_iq_valid),
        .cfg_regs(cfg_regs), .cfg_wr_strobe(cfg_wr_strobe), .status_in(status_in),
        .stage_debug(stage_debug)
    );

    int n_cmp = 0, n_err = 0, stb_cnt = 0, tx_cnt = 0;
    always @(negedge clk_in) begin
        if (cfg_wr_strobe) stb_cnt++;
        if (tx_iq_valid) tx_cnt++;
    end

    typedef struct {
        logic       s;
        logic [7:0] d;
        logic       oe;
        logic [7:0] q;
        logic       chk_q;
        string      nm;
    } vec_t;
    vec_t tv[$];

    task automatic add(input logic s, input logic [7:0] d, input logic oe, input logic [7:0] q,
                       input logic chk_q, input string nm);
        vec_t v;
        v.s = s; v.d = d; v.oe = oe; v.q = q; v.chk_q = chk_q; v.nm = nm;
        tv.push_back(v);
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic [7:0] d, input logic v);
        @(negedge clk_in);
        bus.DATA_SYNC = s; bus.DATA_BUS_IN = d; rx_iq_valid = v;
        @(posedge clk_in);
        #1;
    endtask

    // Bit-serial CRC-8, poly x^8+x^2+x+1, MSB first.
    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[7] ^ d[i];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return r;
    endfunction

    task automatic stat_tail();
        repeat (4) step(1'b0, 8'h00, 1'b0);
    endtask

    logic [7:0] fq[$];
    logic [7:0] txb[8];
    logic [7:0] crc;

    task automatic rx_frame(input string nm, input int chg_at);
        for (int i = 0; i < fq.size(); i++) begin
            if (i == chg_at) rx_chan_en = 2'b11;
            step(1'b0, 8'h00, 1'b0);
            check({nm, "_byte"}, 64'(bus.DATA_BUS_OUT), 64'(fq[i]));
            check({nm, "_req"}, 64'(IQ_RX_READ_REQ), 64'(i == fq.size() - 1));
        end
    endtask

    task automatic build_frame(input logic [63:0] a, input logic [63:0] b, input int n);
        logic [127:0] all;
        all = {a, b};
        fq.delete();
        crc = 8'h00;
        for (int i = 0; i < n; i++) begin
            fq.push_back(all[127 - 8*i -: 8]);
            crc = crc8(crc, all[127 - 8*i -: 8]);
        end
        if (FX == 1) fq.push_back(crc);
    endtask

    initial begin
        bus.DATA_SYNC = 1'b0; bus.DATA_BUS_IN = 8'h00; rx_iq_valid = 1'b0; rx_chan_en = 2'b10;
        rx_iq_data = {32'h55667788, 32'h11223344, 32'hDEADBEEF, 32'hCAFEBABE};
        status_in  = 32'h7CA55A0F;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_oe", 64'(bus.DATA_BUS_OE), 64'(0));
        check("rst_out", 64'(bus.DATA_BUS_OUT), 64'(0));
        check("rst_state", 64'(stage_debug), 64'(0));
        check("rst_cfg", cfg_regs[63:0], 64'(0));
        check("rst_txi", 64'(TX_I), 64'(0));
        check("rst_req", 64'(IQ_RX_READ_REQ), 64'(0));
        @(negedge clk_in);
        reset_n = 1'b1;

        add(1, 8'h00, 0, 8'h00, 1, "echo_cmd");
        add(0, 8'h5A, 1, 8'h5A, 1, "echo_5a");
        add(0, 8'h00, 0, 8'h00, 0, "echo_gap");
        add(0, 8'hA5, 1, 8'hA5, 1, "echo_a5");
        add(0, 8'h00, 0, 8'h00, 0, "echo_gap2");
        add(1, 8'h02, 1, 8'h00, 1, "stat_cmd");
        add(0, 8'h00, 1, B0,    1, "stat_b0");
        add(0, 8'h00, 1, 8'hA5, 1, "stat_b1");
        add(0, 8'h00, 1, 8'h5A, 1, "stat_b2");
        add(0, 8'h00, 1, 8'h0F, 1, "stat_b3");
        add(0, 8'h00, 0, 8'h00, 0, "stat_end");
        add(1, 8'h08, 1, 8'h00, 1, "info_cmd");
        add(0, 8'h00, 1, 8'h02, 1, "info_nrx");
        add(0, 8'h00, 1, 8'h20, 1, "info_iqw");
        add(0, 8'h00, 1, 8'h18, 1, "info_nreg");
        add(0, 8'h00, 1, 8'h02, 1, "info_ver");
        add(0, 8'h00, 0, 8'h00, 0, "info_end");
        add(1, 8'h07, 0, 8'h00, 1, "bad_cmd");
        add(0, 8'h33, 0, 8'h00, 1, "bad_idle");
        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].s, tv[i].d, 1'b0);
            check({tv[i].nm, "_oe"}, 64'(bus.DATA_BUS_OE), 64'(tv[i].oe));
            if (tv[i].chk_q) check({tv[i].nm, "_q"}, 64'(bus.DATA_BUS_OUT), 64'(tv[i].q));
        end

        // Register write 0x01..0x18
        crc = 8'h00;
        step(1'b1, 8'h01, 1'b0);
        for (int i = 0; i < NUM_REGS; i++) begin
            step(1'b0, 8'(i + 1), 1'b0);
            crc = crc8(crc, 8'(i + 1));
        end
`ifdef BUS_CRC_EN
        step(1'b0, crc, 1'b0);
`endif
        check("wreg_stb", 64'(cfg_wr_strobe), 64'(1));
        check("wreg_b0", 64'(cfg_regs[7:0]), 64'h01);
        check("wreg_b23", 64'(cfg_regs[191:184]), 64'h18);
        step(1'b0, 8'h00, 1'b0);
        check("wreg_stb_cnt", 64'(stb_cnt), 64'(1));
        check("wreg_idle", 64'(stage_debug), 64'(0));

        // Abort after 10 bytes
        step(1'b1, 8'h01, 1'b0);
        repeat (10) step(1'b0, 8'hEE, 1'b0);
        step(1'b1, 8'h0F, 1'b0);
        repeat (NUM_REGS) step(1'b0, 8'hEE, 1'b0);
        check("abort_stb_cnt", 64'(stb_cnt), 64'(1));
        check("abort_b0", 64'(cfg_regs[7:0]), 64'h01);
        check("abort_b9", 64'(cfg_regs[79:72]), 64'h0A);

        // TX sample load
        txb = '{8'h00, 8'h00, 8'h01, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00};
        step(1'b1, 8'h03, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, txb[i], 1'b0);
            if (i == 6) check("tx_early", 64'(tx_iq_valid), 64'(0));
        end
        check("tx_vld", 64'(tx_iq_valid), 64'(1));
        check("tx_q", 64'(TX_Q), 64'h00000100);
        check("tx_i", 64'(TX_I), 64'hFFFFFF00);
        step(1'b0, 8'h00, 1'b0);
        check("tx_vld_low", 64'(tx_iq_valid), 64'(0));
        check("tx_cnt", 64'(tx_cnt), 64'(1));

        // RX stream: ch1 only, then mask widened mid-frame (applies from next latch)
        rx_chan_en = 2'b10;
        step(1'b1, 8'h04, 1'b0);
        check("rx_oe", 64'(bus.DATA_BUS_OE), 64'(1));
        check("rx_entry_req", 64'(IQ_RX_READ_REQ), 64'(1));
        build_frame({32'h11223344, 32'h55667788}, 64'h0, 8);
        rx_frame("rx_f1", 4);
        build_frame({32'hCAFEBABE, 32'hDEADBEEF}, {32'h11223344, 32'h55667788}, 16);
        rx_frame("rx_f2", -1);

        // Empty mask: zeros and a latch every cycle
        rx_chan_en = 2'b00;
        step(1'b1, 8'h04, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b0);
            check("rx0_out", 64'(bus.DATA_BUS_OUT), 64'(0));
            check("rx0_req", 64'(IQ_RX_READ_REQ), 64'(1));
        end

        // Strobe on a latch edge belongs to the new interval: no overrun
        rx_chan_en = 2'b10;
        step(1'b1, 8'h04, 1'b0);
        for (int i = 0; i < 8 + FX; i++) step(1'b0, 8'h00, 1'(i == 1 || i == 7 + FX));
        repeat (3) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("ovr_boundary", 64'(bus.DATA_BUS_OUT), 64'(B0));
        stat_tail();

        // Two strobes inside one frame: sticky overrun, cleared by the read
        step(1'b1, 8'h04, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'(i == 1 || i == 3));
        step(1'b1, 8'h02, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("ovr_set", 64'(bus.DATA_BUS_OUT), 64'(B0 | 8'h80));
        stat_tail();
        step(1'b1, 8'h02, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("ovr_clear", 64'(bus.DATA_BUS_OUT), 64'(B0));
        stat_tail();

`ifdef BUS_CRC_EN
        crc = 8'h00;
        step(1'b1, 8'h01, 1'b0);
        for (int i = 0; i < NUM_REGS; i++) begin
            step(1'b0, 8'(8'h30 + i), 1'b0);
            crc = crc8(crc, 8'(8'h30 + i));
        end
        step(1'b0, crc ^ 8'h5A, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("crc_bad_stb_cnt", 64'(stb_cnt), 64'(1));
        check("crc_bad_cfg", 64'(cfg_regs[7:0]), 64'h01);
        step(1'b1, 8'h02, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("crc_err_set", 64'(bus.DATA_BUS_OUT), 64'h7C);
        stat_tail();
        step(1'b1, 8'h02, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("crc_err_clear", 64'(bus.DATA_BUS_OUT), 64'h3C);
        stat_tail();
        step(1'b1, 8'h01, 1'b0);
        for (int i = 0; i < NUM_REGS; i++) step(1'b0, 8'(8'h30 + i), 1'b0);
        step(1'b0, crc, 1'b0);
        check("crc_ok_stb", 64'(cfg_wr_strobe), 64'(1));
        check("crc_ok_cfg", 64'(cfg_regs[7:0]), 64'h30);
        step(1'b0, 8'h00, 1'b0);
        check("crc_ok_stb_cnt", 64'(stb_cnt), 64'(2));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
